// File: rtl/mlp_pkg.sv
// Shared types, constants and saturating arithmetic for the MLP update engine.
package mlp_pkg;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_UPD,
      ST_FIN
   } state_e;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // Adds at full precision and clamps to the signed range of a w-bit word.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int                 w);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/mlp_lfsr16.sv
// 16-bit right-shifting Galois LFSR used to seed the MLP parameters.
module mlp_lfsr16
   import mlp_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        adv,
   output logic [15:0] q
);

   logic [15:0] s_q;
   logic [15:0] s_d;

   always_comb begin
      s_d = s_q;
      if (load) begin
         s_d = SEED;
      end else if (adv) begin
         s_d = s_q[0] ? ((s_q >> 1) ^ LFSR_TAPS) : (s_q >> 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s_q <= SEED;
      else        s_q <= s_d;
   end

   assign q = s_q;

endmodule

// File: rtl/mlp_update_seq.sv
// Sequential backprop update engine: LFSR self-initialisation, then one
// hidden neuron updated per cycle for each accepted start.
module mlp_update_seq
   import mlp_pkg::*;
#(
   parameter int          W    = 8,
   parameter int          N    = 8,
   parameter int          NIN  = 16,
   parameter int          FRAC = 6,
   parameter int          SH_O = 4,
   parameter int          SH_H = 4,
   parameter int          SH_B = 2,
   parameter logic [15:0] SEED = DEFAULT_SEED,
   localparam int         HW   = W + 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     reinit,
   input  logic [NIN-1:0]           x,
   input  logic signed [W-1:0]      err,
   input  logic signed [N*HW-1:0]   h_act_bus,
   output logic                     busy,
   output logic                     done,
   output logic [N*W-1:0]           w_o_bus,
   output logic [W-1:0]             b_o_out,
   output logic [N*NIN*W-1:0]       w_h_bus,
   output logic [N*W-1:0]           b_h_bus
);

   localparam int IW = $clog2(N + 1);
   localparam int JW = $clog2(NIN + 2);

   state_e              state_q, state_d;
   logic [IW-1:0]       ni_q, ni_d;
   logic [JW-1:0]       nj_q, nj_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                done_q, done_d;

   logic signed [W-1:0] w_h_q [N*NIN];
   logic signed [W-1:0] w_h_d [N*NIN];
   logic signed [W-1:0] b_h_q [N];
   logic signed [W-1:0] b_h_d [N];
   logic signed [W-1:0] w_o_q [N];
   logic signed [W-1:0] w_o_d [N];
   logic signed [W-1:0] b_o_q, b_o_d;

   logic [NIN-1:0]      x_q, x_d;
   logic signed [W-1:0] err_q, err_d;
   logic signed [HW-1:0] h_q [N];
   logic signed [HW-1:0] h_d [N];

   logic                lfsr_load, lfsr_adv;
   logic [15:0]         lfsr_q;

   logic signed [W-1:0]  v_wh, v_bh, v_wo;
   logic signed [W-1:0]  wo_sel;
   logic signed [HW-1:0] h_sel;
   logic signed [63:0]   prod, d_wo, d_bh, d_wh_p, d_wh_n, d_bo;

   function automatic logic signed [63:0] shr_floor(input logic signed [63:0] v,
                                                    input int                 sh);
      return v >>> sh;
   endfunction

   function automatic logic signed [W-1:0] sat_w(input logic signed [63:0] a,
                                                 input logic signed [63:0] b);
      logic signed [63:0] s;
      s = sat_add(a, b, W);
      return W'(s);
   endfunction

   mlp_lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load),
      .adv   (lfsr_adv),
      .q     (lfsr_q)
   );

   always_comb begin
      state_d   = state_q;
      ni_d      = ni_q;
      nj_d      = nj_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      x_d       = x_q;
      err_d     = err_q;
      h_d       = h_q;
      w_h_d     = w_h_q;
      b_h_d     = b_h_q;
      w_o_d     = w_o_q;
      b_o_d     = b_o_q;

      v_wh = W'(lfsr_q[3:0]) - W'(8);
      v_bh = W'(lfsr_q[3:0]) - W'(12);
      v_wo = W'(lfsr_q[3:0]);

      // Every delta of a neuron step is derived from the pre-step w_o[k].
      wo_sel = '0;
      h_sel  = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IW'(i)) begin
            wo_sel = w_o_q[i];
            h_sel  = h_q[i];
         end
      end
      prod   = 64'(err_q) * 64'(wo_sel);
      d_wo   = (!h_sel[HW-1] && (h_sel != '0)) ? shr_floor(64'(err_q), SH_O) : 64'sd0;
      d_bh   = shr_floor(prod, SH_H);
      d_wh_p = shr_floor(prod, SH_H + FRAC);
      d_wh_n = shr_floor(-prod, SH_H + FRAC);
      d_bo   = shr_floor(64'(err_q), SH_B);

      case (state_q)
         ST_INIT: begin
            if (ni_q == IW'(N)) begin
               b_o_d   = '0;
               ni_d    = '0;
               nj_d    = '0;
               state_d = ST_IDLE;
            end else begin
               lfsr_adv = 1'b1;
               for (int i = 0; i < N; i++) begin
                  if (ni_q == IW'(i)) begin
                     for (int j = 0; j < NIN; j++) begin
                        if (nj_q == JW'(j)) w_h_d[i*NIN+j] = v_wh;
                     end
                     if (nj_q == JW'(NIN))     b_h_d[i] = v_bh;
                     if (nj_q == JW'(NIN + 1)) w_o_d[i] = v_wo;
                  end
               end
               if (nj_q == JW'(NIN + 1)) begin
                  nj_d = '0;
                  ni_d = ni_q + IW'(1);
               end else begin
                  nj_d = nj_q + JW'(1);
               end
            end
         end
         ST_IDLE: begin
            if (reinit) begin
               lfsr_load = 1'b1;
               ni_d      = '0;
               nj_d      = '0;
               state_d   = ST_INIT;
            end else if (start) begin
               x_d   = x;
               err_d = err;
               for (int i = 0; i < N; i++) h_d[i] = h_act_bus[i*HW +: HW];
               idx_d   = '0;
               state_d = ST_UPD;
            end
         end
         ST_UPD: begin
            for (int i = 0; i < N; i++) begin
               if (idx_q == IW'(i)) begin
                  w_o_d[i] = sat_w(64'(w_o_q[i]), d_wo);
                  b_h_d[i] = sat_w(64'(b_h_q[i]), d_bh);
                  for (int j = 0; j < NIN; j++) begin
                     w_h_d[i*NIN+j] = sat_w(64'(w_h_q[i*NIN+j]), x_q[j] ? d_wh_p : d_wh_n);
                  end
               end
            end
            if (idx_q == IW'(N - 1)) state_d = ST_FIN;
            else                     idx_d   = idx_q + IW'(1);
         end
         ST_FIN: begin
            b_o_d   = sat_w(64'(b_o_q), d_bo);
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         ni_q    <= '0;
         nj_q    <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         w_h_q   <= '{default: '0};
         b_h_q   <= '{default: '0};
         w_o_q   <= '{default: '0};
         b_o_q   <= '0;
      end else begin
         state_q <= state_d;
         ni_q    <= ni_d;
         nj_q    <= nj_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         w_h_q   <= w_h_d;
         b_h_q   <= b_h_d;
         w_o_q   <= w_o_d;
         b_o_q   <= b_o_d;
      end
   end

   // Step operands only matter after a start capture, so they carry no reset.
   always_ff @(posedge clk) begin
      x_q   <= x_d;
      err_q <= err_d;
      h_q   <= h_d;
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign b_o_out = b_o_q;

   for (genvar i = 0; i < N; i++) begin : g_out
      assign w_o_bus[i*W +: W] = w_o_q[i];
      assign b_h_bus[i*W +: W] = b_h_q[i];
      for (genvar j = 0; j < NIN; j++) begin : g_wh
         assign w_h_bus[(i*NIN+j)*W +: W] = w_h_q[i*NIN+j];
      end
   end

endmodule
